// File: rtl/instr_fetch32_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface instr_fetch32_if #(
    parameter int ADDR_W = 14
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch32.sv
// Instruction fetch stage: holds the PC, fetches over a variable-latency
// handshake, presents the instruction and computes the next PC on commit.
module instr_fetch32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic                   clock,
    input  logic                   reset,
    instr_fetch32_if.master        imem,
    output logic [31:0]            Instruction,
    output logic [5:0]             Opcode,
    output logic [5:0]             Function_opcode,
    output logic                   inst_valid,
    input  logic                   ex_stall,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Jr,
    input  logic                   Zero,
    input  logic [31:0]            Read_data_1,
    input  logic [31:0]            Imm_extend,
    output logic [31:0]            pc,
    output logic [31:0]            link_addr,
    output logic                   misalign_err
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] EXEC  = 1'b1;

    logic [0:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        misalign_r;
    logic [31:0] link_s;
    logic [31:0] next_pc_s;

    // Jr beats Jmp/Jal beats a taken branch beats sequential; all arithmetic wraps.
    function automatic logic [31:0] calc_next_pc(
        input logic        jr_f,
        input logic        jmp_f,
        input logic        taken_f,
        input logic [31:0] rs_f,
        input logic [31:0] imm_f,
        input logic [31:0] link_f,
        input logic [31:0] instr_f
    );
        logic [31:0] result;
        if (jr_f) begin
            result = {rs_f[31:2], 2'b00};
        end else if (jmp_f) begin
            result = {link_f[31:28], instr_f[25:0], 2'b00};
        end else if (taken_f) begin
            result = link_f + (imm_f << 2'd2);
        end else begin
            result = link_f;
        end
        return result;
    endfunction

    assign link_s    = pc_r + 32'd4;
    assign next_pc_s = calc_next_pc(Jr, Jmp | Jal,
                                    (Branch & Zero) | (nBranch & ~Zero),
                                    Read_data_1, Imm_extend, link_s, instr_r);

    // Handshake outputs; both are held low while reset is asserted.
    always_comb begin
        imem.req   = 1'b0;
        inst_valid = 1'b0;
        if (!reset) begin
            imem.req   = 1'b0;
            inst_valid = 1'b0;
        end else begin
            case (state_r)
                FETCH:   imem.req   = 1'b1;
                EXEC:    inst_valid = ~ex_stall;
                default: imem.req   = 1'b0;
            endcase
        end
    end

    // FETCH/EXEC sequencing, PC update on commit and sticky jr misalignment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            misalign_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem.ack) begin
                        instr_r <= imem.rdata;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if (!ex_stall) begin
                        pc_r    <= next_pc_s;
                        state_r <= FETCH;
                        if (Jr && (Read_data_1[1:0] != 2'b00)) begin
                            misalign_r <= 1'b1;
                        end
                    end
                end
                default: state_r <= FETCH;
            endcase
        end
    end

    assign imem.addr       = pc_r[ADDR_W+1:2];
    assign Instruction     = instr_r;
    assign Opcode          = instr_r[31:26];
    assign Function_opcode = instr_r[5:0];
    assign pc              = pc_r;
    assign link_addr       = link_s;
    assign misalign_err    = misalign_r;

endmodule

// File: tb/tb_instr_fetch32.sv
// Directed bench for instr_fetch32: startup fetch timing, a table of
// next-PC vectors, then stall and mid-fetch reset sequences.
module tb_instr_fetch32;

    logic        clock;
    logic        reset;
    logic        ex_stall;
    logic        br, nbr, jmp, jal, jr, zero;
    logic [31:0] rd1, imm;
    logic [31:0] instruction, pc, link_addr;
    logic [5:0]  opcode, funct;
    logic        inst_valid, misalign_err;
    int          pass_cnt;
    int          total_cnt;
    int          commits;

    instr_fetch32_if #(.ADDR_W(14)) bus ();

    instr_fetch32 #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
        .clock(clock), .reset(reset), .imem(bus),
        .Instruction(instruction), .Opcode(opcode), .Function_opcode(funct),
        .inst_valid(inst_valid), .ex_stall(ex_stall),
        .Branch(br), .nBranch(nbr), .Jmp(jmp), .Jal(jal), .Jr(jr), .Zero(zero),
        .Read_data_1(rd1), .Imm_extend(imm),
        .pc(pc), .link_addr(link_addr), .misalign_err(misalign_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (inst_valid) commits <= commits + 1;
    end

    typedef struct {
        logic [31:0] pc0;
        logic [31:0] instr;
        logic [5:0]  ctl;     // {Branch, nBranch, Jmp, Jal, Jr, Zero}
        logic [31:0] rs;
        logic [31:0] imm;
        logic [31:0] pc1;
        logic        mis;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] p0, input logic [31:0] ins,
                                input logic [5:0] c, input logic [31:0] r,
                                input logic [31:0] im, input logic [31:0] p1,
                                input logic m);
        vec_t v;
        v.pc0 = p0; v.instr = ins; v.ctl = c; v.rs = r; v.imm = im; v.pc1 = p1; v.mis = m;
        return v;
    endfunction

    initial begin
        logic [7:0] ack_pat;
        logic [7:0] val_pat;
        int         exp_addr [8];
        logic [31:0] cnt0;

        pass_cnt = 0; total_cnt = 0; commits = 0;
        reset = 1'b0; ex_stall = 1'b0; bus.ack = 1'b0; bus.rdata = 32'h0;
        {br, nbr, jmp, jal, jr, zero} = 6'b0; rd1 = 32'h0; imm = 32'h0;

        // ctl = {Branch, nBranch, Jmp, Jal, Jr, Zero}
        vecs[0]  = mk(32'h0000_000C, 32'h03E0_0008, 6'b000010, 32'h0000_0010, 32'h0, 32'h0000_0010, 1'b0);
        vecs[1]  = mk(32'h0000_0010, 32'h1000_FFFF, 6'b100001, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0);
        vecs[2]  = mk(32'h0000_0004, 32'h03E0_0008, 6'b000010, 32'h0000_0010, 32'h0, 32'h0000_0010, 1'b0);
        vecs[3]  = mk(32'h0000_0010, 32'h1000_FFFF, 6'b100000, 32'h0, 32'hFFFF_FFFC, 32'h0000_0014, 1'b0);
        vecs[4]  = mk(32'h0000_0014, 32'h03E0_0008, 6'b000010, 32'h0000_0010, 32'h0, 32'h0000_0010, 1'b0);
        vecs[5]  = mk(32'h0000_0010, 32'h1400_FFFF, 6'b010000, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0);
        vecs[6]  = mk(32'h0000_0004, 32'h03E0_0008, 6'b000010, 32'h0000_0010, 32'h0, 32'h0000_0010, 1'b0);
        vecs[7]  = mk(32'h0000_0010, 32'h1400_FFFF, 6'b010001, 32'h0, 32'hFFFF_FFFC, 32'h0000_0014, 1'b0);
        vecs[8]  = mk(32'h0000_0014, 32'h03E0_0008, 6'b000010, 32'h1000_0040, 32'h0, 32'h1000_0040, 1'b0);
        vecs[9]  = mk(32'h1000_0040, 32'h0800_0100, 6'b001000, 32'h0, 32'h0, 32'h1000_0400, 1'b0);
        vecs[10] = mk(32'h1000_0400, 32'h03E0_0008, 6'b000010, 32'h1000_0040, 32'h0, 32'h1000_0040, 1'b0);
        vecs[11] = mk(32'h1000_0040, 32'h0C00_0100, 6'b000100, 32'h0, 32'h0, 32'h1000_0400, 1'b0);
        vecs[12] = mk(32'h1000_0400, 32'h03E0_0008, 6'b000010, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0);
        vecs[13] = mk(32'hFFFF_FFFC, 32'h0000_0020, 6'b000000, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
        vecs[14] = mk(32'h0000_0000, 32'h0800_0010, 6'b101011, 32'h0000_0020, 32'h1, 32'h0000_0020, 1'b0);
        vecs[15] = mk(32'h0000_0020, 32'h0800_0010, 6'b101001, 32'h0, 32'hFFFF_FFFC, 32'h0000_0040, 1'b0);
        vecs[16] = mk(32'h0000_0040, 32'h1000_FFFF, 6'b100001, 32'h0, 32'h7FFF_FFFF, 32'h0000_0040, 1'b0);
        vecs[17] = mk(32'h0000_0040, 32'h03E0_0008, 6'b000010, 32'h0000_0102, 32'h0, 32'h0000_0100, 1'b1);
        vecs[18] = mk(32'h0000_0100, 32'h0000_0020, 6'b000000, 32'h0, 32'h0, 32'h0000_0104, 1'b1);

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req", {31'b0, bus.req}, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);

        // Startup: ack 0-wait, 2-wait, 0-wait; commits on cycles 2, 6, 8
        ack_pat = 8'b0101_0001;
        val_pat = 8'b1010_0010;
        exp_addr = '{0, 0, 1, 1, 1, 0, 2, 0};
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("seq_valid_c%0d", c + 1), {31'b0, inst_valid}, {31'b0, val_pat[c]});
            check($sformatf("seq_req_c%0d", c + 1), {31'b0, bus.req}, {31'b0, ~val_pat[c]});
            if (!val_pat[c]) check($sformatf("seq_addr_c%0d", c + 1), {18'b0, bus.addr}, exp_addr[c]);
            bus.ack = ack_pat[c];
            bus.rdata = 32'h0000_0020;
            @(negedge clock);
        end
        bus.ack = 1'b0;

        // Next-PC table
        for (int i = 0; i < 19; i++) begin
            check($sformatf("v%0d_pc0", i), pc, vecs[i].pc0);
            check($sformatf("v%0d_req", i), {31'b0, bus.req}, 32'h1);
            check($sformatf("v%0d_addr", i), {18'b0, bus.addr}, {18'b0, vecs[i].pc0[15:2]});
            bus.ack = 1'b1; bus.rdata = vecs[i].instr;
            @(negedge clock);
            bus.ack = 1'b0;
            {br, nbr, jmp, jal, jr, zero} = vecs[i].ctl;
            rd1 = vecs[i].rs; imm = vecs[i].imm;
            #1;
            check($sformatf("v%0d_valid", i), {31'b0, inst_valid}, 32'h1);
            check($sformatf("v%0d_instr", i), instruction, vecs[i].instr);
            check($sformatf("v%0d_opcode", i), {26'b0, opcode}, {26'b0, vecs[i].instr[31:26]});
            check($sformatf("v%0d_funct", i), {26'b0, funct}, {26'b0, vecs[i].instr[5:0]});
            check($sformatf("v%0d_link", i), link_addr, vecs[i].pc0 + 32'd4);
            @(negedge clock);
            check($sformatf("v%0d_pc1", i), pc, vecs[i].pc1);
            check($sformatf("v%0d_misalign", i), {31'b0, misalign_err}, {31'b0, vecs[i].mis});
            {br, nbr, jmp, jal, jr, zero} = 6'b0; rd1 = 32'h0; imm = 32'h0;
        end

        // Stall for 3 cycles with stray ack and garbage controls, then commit
        cnt0 = commits;
        bus.ack = 1'b1; bus.rdata = 32'h0000_0020;
        @(negedge clock);
        ex_stall = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        jr = 1'b1; rd1 = 32'h0000_8000;
        for (int s = 0; s < 3; s++) begin
            #1;
            check($sformatf("stall%0d_valid", s), {31'b0, inst_valid}, 32'h0);
            check($sformatf("stall%0d_req", s), {31'b0, bus.req}, 32'h0);
            check($sformatf("stall%0d_pc", s), pc, 32'h0000_0104);
            check($sformatf("stall%0d_instr", s), instruction, 32'h0000_0020);
            @(negedge clock);
        end
        ex_stall = 1'b0; bus.ack = 1'b0; jr = 1'b0; rd1 = 32'h0;
        #1;
        check("stall_release_valid", {31'b0, inst_valid}, 32'h1);
        check("stall_release_instr", instruction, 32'h0000_0020);
        @(negedge clock);
        check("stall_next_pc", pc, 32'h0000_0108);
        check("stall_commits", commits - cnt0, 32'd1);
        check("stall_misalign_sticky", {31'b0, misalign_err}, 32'h1);

        // Reset asserted while FETCH waits for ack
        cnt0 = commits;
        @(negedge clock);
        check("midrst_req_before", {31'b0, bus.req}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("midrst_req", {31'b0, bus.req}, 32'h0);
        check("midrst_valid", {31'b0, inst_valid}, 32'h0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_misalign", {31'b0, misalign_err}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_commits", commits - cnt0, 32'd0);
        check("midrst_req_after", {31'b0, bus.req}, 32'h1);
        check("midrst_addr_after", {18'b0, bus.addr}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch32.md
# instr_fetch32

Instruction fetch stage of the single-cycle MIPS core. It holds the PC, fetches each instruction from an instruction memory with a variable-latency request/acknowledge handshake, and presents the instruction to the controller and decoder. It then computes the next PC from the controller's Branch/nBranch/Jmp/Jal/Jr outputs, the ALU Zero flag, the register-file rs value and the sign-extended immediate. It sits directly upstream of the controller.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, word aligned)
- ADDR_W, 14, instruction-memory word-address width

- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  word address, equal to PC[ADDR_W+1:2]
- imem_ack  in  1  memory response; imem_rdata is valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- Instruction  out  32  registered current instruction
- Opcode  out  6  Instruction[31:26], to controller
- Function_opcode  out  6  Instruction[5:0], to controller
- inst_valid  out  1  instruction commits this cycle; downstream stages write state only when high
- ex_stall  in  1  downstream hold (I/O or data-memory wait); blocks commit
- Branch, nBranch, Jmp, Jal, Jr  in  1 each  controller decode of Instruction
- Zero  in  1  ALU result == 0
- Read_data_1  in  32  rs value (jr target)
- Imm_extend  in  32  sign-extended immediate
- pc  out  32  current PC
- link_addr  out  32  PC+4, the value jal writes to $31
- misalign_err  out  1  sticky flag: a jr target had nonzero bits [1:0]

## Operation
- Two states, FETCH and EXEC. The state register resets to FETCH.
- FETCH:
  - imem_req=1 and inst_valid=0.
  - On the cycle imem_ack=1: Instruction <= imem_rdata and state -> EXEC.
  - With no ack, stay in FETCH with imem_req held high and imem_addr stable.
- EXEC:
  - imem_req=0 and inst_valid=!ex_stall.
  - When inst_valid=1: PC <= next_pc and state -> FETCH.
  - When ex_stall=1: stay in EXEC; Instruction and PC are held.
- next_pc priority (highest first):
  - Jr: {Read_data_1[31:2],2'b00}. If Read_data_1[1:0]!=0 at commit, set misalign_err.
  - Jmp or Jal: {link_addr[31:28], Instruction[25:0], 2'b00}.
  - (Branch && Zero) or (nBranch && !Zero): link_addr + (Imm_extend << 2).
  - Otherwise: link_addr.
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Branch-offset overflow is discarded.
- imem_ack outside FETCH is ignored. ex_stall outside EXEC is ignored.
- Control inputs are sampled only on the commit cycle.
- misalign_err clears only on reset.

## Timing
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, Instruction=0 (nop), state=FETCH, misalign_err=0.
  - imem_req and inst_valid are forced 0 combinationally while reset is low.
- Reset asserted mid-fetch or mid-stall aborts the instruction; no commit occurs.
- First imem_req is in the first cycle after reset deasserts.
- Minimum throughput: one instruction per 2 cycles, with ack in the first FETCH cycle and no stall. Each cycle of ack delay or ex_stall adds one cycle.
- Opcode, Function_opcode, pc and link_addr are valid throughout EXEC and stable for the whole of a stall.
- The new PC appears on pc and imem_addr in the cycle after commit.

## Test plan
- Reset and sequential fetch: ack with 0 and 2 wait cycles from PC=0.
  - Required: imem_addr sequence 0,1,2.
  - inst_valid pulses one cycle each, on cycles 2, 6, 8 (ack 0-wait gives a 2-cycle instruction, 2-wait gives 4).
- Branches at PC=0x10 with Imm_extend=0xFFFF_FFFC:
  - beq with Zero=1: next pc=0x04.
  - beq with Zero=0: next pc=0x14.
  - bne with Zero=0: next pc=0x04.
- Jumps at PC=0x1000_0040 with Instruction[25:0]=0x0000100:
  - j and jal: next pc=0x1000_0400.
  - jal: link_addr=0x1000_0044 during EXEC.
- jr with Read_data_1=0x0000_0102:
  - next pc=0x0000_0100 and misalign_err=1.
  - misalign_err stays 1 after the following instructions until reset.
- ex_stall held 3 cycles in EXEC:
  - inst_valid=0 during the stall.
  - PC and Instruction unchanged; single commit when the stall drops.
  - Stray imem_ack during EXEC is ignored.
- Wrap and mid-fetch reset:
  - PC=0xFFFF_FFFC sequential: next pc=0.
  - Reset asserted during a FETCH wait: imem_req drops immediately and pc=RESET_PC.
